// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack imem port, one-entry skid buffer and type classifier.
// state | meaning:  FETCH request at pc | BUF holding a stalled word | DRAIN discard stale ack
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] if_inst,
  output logic [31:0] if_new_pc,
  output logic [3:0]  if_inst_num,
  output logic [3:0]  if_inst_type,
  output logic        if_valid
);

  typedef enum logic [1:0] {FETCH, BUF, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] drain_addr, drain_addr_nx;
  logic [31:0] buf_inst, buf_inst_nx;
  logic [31:0] buf_pc, buf_pc_nx;
  logic [3:0]  count, count_nx;
  logic [31:0] inst_nx, new_pc_nx;
  logic [3:0]  num_nx, type_nx;
  logic        valid_nx;
  logic        deliver, bubble;
  logic [31:0] deliver_inst, deliver_pc;

  function automatic logic [3:0] decode(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (w == 32'd0)                       return 4'd0;
    if (op == 6'h00)                      return 4'd1;
    if (op >= 6'h08 && op <= 6'h0F)       return 4'd2;
    if (op == 6'h23)                      return 4'd3;
    if (op == 6'h2B)                      return 4'd4;
    if (op == 6'h04 || op == 6'h05)       return 4'd5;
    if (op == 6'h02 || op == 6'h03)       return 4'd6;
    return 4'd15;
  endfunction

  // Reset gates the request so the port is quiet while reset is asserted.
  assign imem_req  = !reset && (state != BUF);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    drain_addr_nx = drain_addr;
    buf_inst_nx   = buf_inst;
    buf_pc_nx     = buf_pc;
    count_nx      = count;
    inst_nx       = if_inst;
    new_pc_nx     = if_new_pc;
    num_nx        = if_inst_num;
    type_nx       = if_inst_type;
    valid_nx      = if_valid;
    deliver       = 1'b0;
    bubble        = 1'b0;
    deliver_inst  = imem_rdata;
    deliver_pc    = pc;

    if (branch_taken) begin
      pc_nx  = branch_target & ~32'd3;
      bubble = 1'b1;
      // A request still unanswered must be drained at its old address.
      if (state != BUF && !imem_ack) begin
        state_nx      = DRAIN;
        drain_addr_nx = imem_addr;
      end else begin
        state_nx = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            pc_nx = pc + PC_STEP;
            if (stall) begin
              buf_inst_nx = imem_rdata;
              buf_pc_nx   = pc;
              state_nx    = BUF;
            end else begin
              deliver = 1'b1;
            end
          end else if (!stall) begin
            bubble = 1'b1;
          end
        end
        BUF: begin
          if (!stall) begin
            deliver      = 1'b1;
            deliver_inst = buf_inst;
            deliver_pc   = buf_pc;
            state_nx     = FETCH;
          end
        end
        DRAIN: begin
          bubble = 1'b1;
          if (imem_ack) state_nx = FETCH;
        end
        default: state_nx = FETCH;
      endcase
    end

    if (deliver) begin
      inst_nx   = deliver_inst;
      new_pc_nx = deliver_pc + PC_STEP;
      num_nx    = count;
      type_nx   = decode(deliver_inst);
      valid_nx  = 1'b1;
      count_nx  = count + 4'd1;
    end
    if (bubble) begin
      inst_nx  = 32'd0;
      type_nx  = 4'd0;
      valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      drain_addr   <= RESET_PC;
      buf_inst     <= 32'd0;
      buf_pc       <= 32'd0;
      count        <= 4'd0;
      if_inst      <= 32'd0;
      if_new_pc    <= 32'd0;
      if_inst_num  <= 4'd0;
      if_inst_type <= 4'd0;
      if_valid     <= 1'b0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      drain_addr   <= drain_addr_nx;
      buf_inst     <= buf_inst_nx;
      buf_pc       <= buf_pc_nx;
      count        <= count_nx;
      if_inst      <= inst_nx;
      if_new_pc    <= new_pc_nx;
      if_inst_num  <= num_nx;
      if_inst_type <= type_nx;
      if_valid     <= valid_nx;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] STEP     = 32'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_target = 32'd0, imem_rdata = 32'd0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_inst, if_new_pc;
  logic [3:0]  if_inst_num, if_inst_type;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  if_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(STEP)) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .if_inst(if_inst),
    .if_new_pc(if_new_pc), .if_inst_num(if_inst_num), .if_inst_type(if_inst_type),
    .if_valid(if_valid)
  );

  // Behavioural model: a queue for the skid buffer, a running delivery count.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } entry_t;
  entry_t      skid[$];
  logic [31:0] m_pc, m_drain_addr, m_inst, m_new_pc;
  logic [3:0]  m_type, m_num;
  logic        m_valid, m_draining;
  int          m_delivered;
  logic        prev_hold;
  logic [31:0] prev_addr;

  function automatic logic [3:0] ref_type(input logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    if (w == 32'd0) return 4'd0;
    case (op)
      0:                             return 4'd1;
      8, 9, 10, 11, 12, 13, 14, 15:  return 4'd2;
      35:                            return 4'd3;
      43:                            return 4'd4;
      4, 5:                          return 4'd5;
      2, 3:                          return 4'd6;
      default:                       return 4'd15;
    endcase
  endfunction

  function automatic logic exp_req();
    return skid.size() == 0;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_draining ? m_drain_addr : m_pc;
  endfunction

  function automatic logic [31:0] rand_word();
    int k;
    logic [5:0] op;
    k = int'($urandom_range(0, 15));
    case (k)
      0: op = 6'h00;
      1: op = 6'(8 + $urandom_range(0, 7));
      2: op = 6'h23;
      3: op = 6'h2B;
      4: op = 6'h04;
      5: op = 6'h05;
      6: op = 6'h02;
      7: op = 6'h03;
      8: op = 6'h3F;
      default: op = 6'($urandom);
    endcase
    if (k == 15) return 32'd0;
    return {op, 26'($urandom)};
  endfunction

  task automatic model_reset();
    skid.delete();
    m_pc = RESET_PC; m_drain_addr = RESET_PC; m_inst = 0; m_new_pc = 0;
    m_type = 0; m_num = 0; m_valid = 0; m_draining = 0; m_delivered = 0;
    prev_hold = 0; prev_addr = 0;
  endtask

  task automatic m_bubble();
    m_inst = 0; m_type = 0; m_valid = 0;
  endtask

  task automatic m_deliver(input logic [31:0] w, input logic [31:0] p);
    m_inst = w; m_type = ref_type(w); m_new_pc = p + STEP;
    m_num = 4'(m_delivered % 16); m_delivered++; m_valid = 1;
  endtask

  task automatic model_step();
    entry_t e;
    logic req_now;
    req_now = exp_req();
    if (branch_taken) begin
      if (req_now && !imem_ack) begin
        m_drain_addr = exp_addr();
        m_draining   = 1;
      end else begin
        m_draining = 0;
      end
      skid.delete();
      m_pc = branch_target & ~32'd3;
      m_bubble();
    end else if (m_draining) begin
      m_bubble();
      if (imem_ack) m_draining = 0;
    end else if (skid.size() != 0) begin
      if (!stall) begin
        e = skid.pop_front();
        m_deliver(e.inst, e.pc);
      end
    end else if (imem_ack) begin
      if (stall) begin
        e.inst = imem_rdata; e.pc = m_pc;
        skid.push_back(e);
      end else begin
        m_deliver(imem_rdata, m_pc);
      end
      m_pc = m_pc + STEP;
    end else if (!stall) begin
      m_bubble();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("imem_req", 32'(imem_req), 32'(exp_req()));
    if (exp_req()) chk("imem_addr", imem_addr, exp_addr());
    if (prev_hold) chk("addr_stable", imem_addr, prev_addr);
    chk("if_inst", if_inst, m_inst);
    chk("if_new_pc", if_new_pc, m_new_pc);
    chk("if_inst_num", 32'(if_inst_num), 32'(m_num));
    chk("if_inst_type", 32'(if_inst_type), 32'(m_type));
    chk("if_valid", 32'(if_valid), 32'(m_valid));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic st, input logic br, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rd);
    compare_all();
    stall = st; branch_taken = br; branch_target = tgt;
    imem_ack = ack && exp_req(); imem_rdata = rd;
    prev_hold = exp_req() && !imem_ack;
    prev_addr = exp_addr();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1; stall = 0; branch_taken = 0; imem_ack = 0; imem_rdata = 0; branch_target = 0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_new_pc", if_new_pc, 32'd0);
    chk("rst_num", 32'(if_inst_num), 32'd0);
    chk("rst_type", 32'(if_inst_type), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] w;
    #1;
    apply_reset();

    // Zero-wait memory
    cycle(0, 0, 0, 1, 32'h8C010004);
    chk("zw0_type", 32'(if_inst_type), 32'd3); chk("zw0_pc", if_new_pc, 32'h4);
    chk("zw0_num", 32'(if_inst_num), 32'd0);   chk("zw0_valid", 32'(if_valid), 32'd1);
    cycle(0, 0, 0, 1, 32'h00221820);
    chk("zw1_type", 32'(if_inst_type), 32'd1); chk("zw1_pc", if_new_pc, 32'h8);
    chk("zw1_num", 32'(if_inst_num), 32'd1);
    cycle(0, 0, 0, 1, 32'h1000FFFF);
    chk("zw2_type", 32'(if_inst_type), 32'd5); chk("zw2_pc", if_new_pc, 32'hC);
    chk("zw2_num", 32'(if_inst_num), 32'd2);

    // Two-cycle latency memory
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 0, 32'hDEADBEEF);
      chk("lat_bubble_valid", 32'(if_valid), 32'd0);
      chk("lat_bubble_inst", if_inst, 32'd0);
      cycle(0, 0, 0, 1, 32'h20010001 + 32'(i));
      chk("lat_valid", 32'(if_valid), 32'd1);
    end

    // Stall with ack arriving while stalled
    cycle(1, 0, 0, 0, 32'h0);
    chk("stall_hold_valid", 32'(if_valid), 32'd1);
    chk("stall_hold_inst", if_inst, 32'h20010002);
    cycle(1, 0, 0, 1, 32'hAC220008);
    chk("buf_req", 32'(imem_req), 32'd0);
    chk("buf_hold_inst", if_inst, 32'h20010002);
    cycle(1, 0, 0, 1, 32'h0);
    chk("buf_req2", 32'(imem_req), 32'd0);
    cycle(0, 0, 0, 0, 32'h0);
    chk("buf_out_inst", if_inst, 32'hAC220008);
    chk("buf_out_num", 32'(if_inst_num), 32'd5);
    chk("buf_out_type", 32'(if_inst_type), 32'd4);
    chk("buf_out_pc", if_new_pc, 32'h18);

    // Redirect with a request pending
    cycle(0, 1, 32'h0000_0102, 0, 32'h0);
    chk("drain_valid", 32'(if_valid), 32'd0);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_addr", imem_addr, 32'h18);
    cycle(0, 0, 0, 1, 32'h8C000000);
    chk("drain_disc_valid", 32'(if_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    cycle(0, 0, 0, 1, 32'h20010001);
    chk("redir_num", 32'(if_inst_num), 32'd6);
    chk("redir_pc", if_new_pc, 32'h104);
    chk("redir_type", 32'(if_inst_type), 32'd2);

    // 17 deliveries from reset: sequence numbers wrap
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      w = (i == 5) ? 32'hFC000000 : rand_word();
      cycle(0, 0, 0, 1, w);
      chk("wrap_num", 32'(if_inst_num), 32'(i % 16));
      chk("wrap_pc", if_new_pc, 32'((i + 1) * 4));
      if (i == 5) chk("op3f_type", 32'(if_inst_type), 32'd15);
    end

    // Reset asserted while in BUF
    cycle(1, 0, 0, 1, 32'h8C010004);
    chk("pre_rst_buf_req", 32'(imem_req), 32'd0);
    compare_all();
    #2;
    apply_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 2) == 0, rand_word());
    end
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
